// File: rtl/systolic_ctrl.sv
// systolic_ctrl: weight-load / skewed input-stream / psum-token sequencer for a weight-stationary array.
// Outputs are registered from the next-state values, so they line up with the state they describe.
module systolic_ctrl #(
    parameter int PE_ROW     = 8,
    parameter int PE_COL     = 8,
    parameter int BIT_ROW_ID = 3,
    parameter int BIT_ADDR   = 8,
    parameter int BIT_VALID  = 1,
    parameter int BIT_CNT    = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          i_Start,
    input  logic [BIT_CNT-1:0]            i_Num_Vec,
    input  logic [BIT_ADDR-1:0]           i_Base_Addr,
    output logic                          o_Busy,
    output logic                          o_Done,
    output logic                          o_W_Rd_En,
    output logic [BIT_ROW_ID-1:0]         o_W_Rd_Addr,
    output logic [PE_COL-1:0]             o_EN_W,
    output logic [BIT_ROW_ID-1:0]         o_EN_ID,
    output logic [PE_ROW-1:0]             o_I_Rd_En,
    output logic [PE_ROW*BIT_CNT-1:0]     o_I_Rd_Addr,
    output logic [PE_COL*BIT_ADDR-1:0]    o_Addr_P,
    output logic [PE_COL*BIT_VALID-1:0]   o_Valid_P
);
    // wide enough for the final stream index N+PE_ROW+PE_COL-2 at the largest N
    localparam int BIT_T = $clog2((2 ** BIT_CNT) + PE_ROW + PE_COL);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

    state_t                        state, state_nx;
    logic [BIT_T-1:0]              cnt, cnt_nx, last_t;
    logic [BIT_CNT-1:0]            num, num_nx;
    logic [BIT_ADDR-1:0]           base, base_nx;
    logic                          w_en_nx;
    logic [BIT_ROW_ID-1:0]         w_addr_nx;
    logic [PE_ROW-1:0]             i_en_nx;
    logic [PE_ROW*BIT_CNT-1:0]     i_addr_nx;
    logic [PE_COL*BIT_ADDR-1:0]    addr_p_nx;
    logic [PE_COL*BIT_VALID-1:0]   valid_p_nx;

    assign last_t = BIT_T'(num) + BIT_T'(PE_ROW + PE_COL - 2);

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        num_nx     = num;
        base_nx    = base;
        i_en_nx    = '0;
        i_addr_nx  = '0;
        addr_p_nx  = '0;
        valid_p_nx = '0;
        case (state)
            IDLE: begin
                state_nx = i_Start ? LOAD : IDLE;
                num_nx   = i_Start ? i_Num_Vec : num;
                base_nx  = i_Start ? i_Base_Addr : base;
                cnt_nx   = '0;
            end
            LOAD: begin
                state_nx = cnt == BIT_T'(PE_ROW) ? (num == '0 ? DONE : STREAM) : LOAD;
                cnt_nx   = cnt == BIT_T'(PE_ROW) ? '0 : cnt + BIT_T'(1);
            end
            STREAM: begin
                state_nx = cnt == last_t ? DONE : STREAM;
                cnt_nx   = cnt == last_t ? '0 : cnt + BIT_T'(1);
            end
            default: state_nx = IDLE;
        endcase
        // the final LOAD beat carries only the delayed EN_W/EN_ID, no new read
        w_en_nx   = state_nx == LOAD && cnt_nx < BIT_T'(PE_ROW);
        w_addr_nx = w_en_nx ? BIT_ROW_ID'(cnt_nx) : '0;
        for (int j = 0; j < PE_ROW; j++) begin
            i_en_nx[j] = state_nx == STREAM && cnt_nx >= BIT_T'(j) &&
                         cnt_nx < BIT_T'(j) + BIT_T'(num_nx);
            i_addr_nx[j*BIT_CNT+:BIT_CNT] = i_en_nx[j] ? BIT_CNT'(cnt_nx - BIT_T'(j)) : '0;
        end
        for (int i = 0; i < PE_COL; i++) begin
            if (state_nx == STREAM && cnt_nx >= BIT_T'(i) && cnt_nx < BIT_T'(i) + BIT_T'(num_nx)) begin
                valid_p_nx[i*BIT_VALID+:BIT_VALID] = BIT_VALID'(1);
                addr_p_nx[i*BIT_ADDR+:BIT_ADDR]    = base_nx + BIT_ADDR'(cnt_nx - BIT_T'(i));
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            cnt         <= '0;
            num         <= '0;
            base        <= '0;
            o_Busy      <= 1'b0;
            o_Done      <= 1'b0;
            o_W_Rd_En   <= 1'b0;
            o_W_Rd_Addr <= '0;
            o_EN_W      <= '0;
            o_EN_ID     <= '0;
            o_I_Rd_En   <= '0;
            o_I_Rd_Addr <= '0;
            o_Addr_P    <= '0;
            o_Valid_P   <= '0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            num         <= num_nx;
            base        <= base_nx;
            o_Busy      <= state_nx != IDLE;
            o_Done      <= state_nx == DONE;
            o_W_Rd_En   <= w_en_nx;
            o_W_Rd_Addr <= w_addr_nx;
            o_EN_W      <= {PE_COL{o_W_Rd_En}};
            o_EN_ID     <= o_W_Rd_Addr;
            o_I_Rd_En   <= i_en_nx;
            o_I_Rd_Addr <= i_addr_nx;
            o_Addr_P    <= addr_p_nx;
            o_Valid_P   <= valid_p_nx;
        end
    end
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: job table plus random jobs checked cycle by cycle against a timeline model
// that derives every output from the cycle offset since the accepted start.
module tb_systolic_ctrl;
    localparam int PE_ROW = 4;
    localparam int PE_COL = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        i_Start = 1'b0;
    logic [7:0]  i_Num_Vec = '0;
    logic [7:0]  i_Base_Addr = '0;
    logic        o_Busy, o_Done, o_W_Rd_En;
    logic [2:0]  o_W_Rd_Addr, o_EN_ID;
    logic [3:0]  o_EN_W, o_I_Rd_En, o_Valid_P;
    logic [31:0] o_I_Rd_Addr, o_Addr_P;

    systolic_ctrl #(
        .PE_ROW(PE_ROW), .PE_COL(PE_COL), .BIT_ROW_ID(3),
        .BIT_ADDR(8), .BIT_VALID(1), .BIT_CNT(8)
    ) dut (
        .CLK(CLK), .RST(RST), .i_Start(i_Start), .i_Num_Vec(i_Num_Vec),
        .i_Base_Addr(i_Base_Addr), .o_Busy(o_Busy), .o_Done(o_Done),
        .o_W_Rd_En(o_W_Rd_En), .o_W_Rd_Addr(o_W_Rd_Addr), .o_EN_W(o_EN_W),
        .o_EN_ID(o_EN_ID), .o_I_Rd_En(o_I_Rd_En), .o_I_Rd_Addr(o_I_Rd_Addr),
        .o_Addr_P(o_Addr_P), .o_Valid_P(o_Valid_P)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        busy, done, wren;
        logic [2:0]  waddr;
        logic [3:0]  enw;
        logic [2:0]  enid;
        logic [3:0]  ien;
        logic [31:0] iaddr;
        logic [31:0] addrp;
        logic [3:0]  validp;
    } snap_t;

    typedef struct {
        int         n;
        int         base;
        bit         b2b;
        bit         inject;
        int         done_lat;
        int         strobes;
        logic [7:0] col0_last;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    snap_t obs [0:511];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic snap_t sample();
        snap_t s;
        s = '{o_Busy, o_Done, o_W_Rd_En, o_W_Rd_Addr, o_EN_W, o_EN_ID,
              o_I_Rd_En, o_I_Rd_Addr, o_Addr_P, o_Valid_P};
        return s;
    endfunction

    // Expected outputs k cycles after the edge that accepted a start with N=n.
    function automatic snap_t model(int k, int n, int base);
        snap_t e = '0;
        int stream0 = PE_ROW + 2;
        int len = n + PE_ROW + PE_COL - 1;
        int done_k = (n == 0) ? stream0 : stream0 + len;
        int t;
        e.busy = k >= 1 && k <= done_k;
        e.done = k == done_k;
        if (k >= 1 && k <= PE_ROW) begin
            e.wren  = 1'b1;
            e.waddr = 3'(k - 1);
        end
        if (k >= 2 && k <= PE_ROW + 1) begin
            e.enw  = 4'hF;
            e.enid = 3'(k - 2);
        end
        if (n > 0 && k >= stream0 && k < stream0 + len) begin
            t = k - stream0;
            for (int j = 0; j < PE_ROW; j++)
                if (t >= j && t < j + n) begin
                    e.ien[j] = 1'b1;
                    e.iaddr[j*8+:8] = 8'(t - j);
                end
            for (int i = 0; i < PE_COL; i++)
                if (t >= i && t < i + n) begin
                    e.validp[i] = 1'b1;
                    e.addrp[i*8+:8] = 8'((base + t - i) % 256);
                end
        end
        return e;
    endfunction

    task automatic cmp(input string tag, input snap_t g, input snap_t e);
        chk({tag, ".busy"},   32'(g.busy),   32'(e.busy));
        chk({tag, ".done"},   32'(g.done),   32'(e.done));
        chk({tag, ".w_en"},   32'(g.wren),   32'(e.wren));
        chk({tag, ".w_addr"}, 32'(g.waddr),  32'(e.waddr));
        chk({tag, ".en_w"},   32'(g.enw),    32'(e.enw));
        chk({tag, ".en_id"},  32'(g.enid),   32'(e.enid));
        chk({tag, ".i_en"},   32'(g.ien),    32'(e.ien));
        chk({tag, ".i_addr"}, g.iaddr,       e.iaddr);
        chk({tag, ".addr_p"}, g.addrp,       e.addrp);
        chk({tag, ".valid_p"},32'(g.validp), 32'(e.validp));
    endtask

    // Starts a job from an idle DUT and returns on the first idle cycle after o_Done.
    task automatic run_job(input string nm, input int n, input int base, input bit inject,
                           output int done_k, output int strobes,
                           output logic [7:0] col0_last, output int dones);
        int last_k = PE_ROW + 2 + ((n == 0) ? 0 : n + PE_ROW + PE_COL - 1) + 1;
        i_Start = 1'b1;
        i_Num_Vec = n[7:0];
        i_Base_Addr = base[7:0];
        done_k = -1;
        strobes = 0;
        col0_last = '0;
        dones = 0;
        for (int k = 1; k <= last_k; k++) begin
            step();
            i_Start = inject && n > 0 && k == PE_ROW + 3;
            i_Num_Vec = 8'($urandom);
            i_Base_Addr = 8'($urandom);
            obs[k] = sample();
            cmp($sformatf("%s k=%0d", nm, k), obs[k], model(k, n, base));
            if (obs[k].done) begin
                dones++;
                if (done_k < 0) done_k = k;
            end
            strobes += $countones(obs[k].ien);
            if (obs[k].validp[0]) col0_last = obs[k].addrp[7:0];
        end
        i_Start = 1'b0;
    endtask

    vec_t vecs [7];

    initial begin
        int         dk, st, dn;
        logic [7:0] c0;
        vecs[0] = '{2,   8'h00, 1'b0, 1'b0, 15,  8,    8'h01};
        vecs[1] = '{3,   8'h10, 1'b0, 1'b0, 16,  12,   8'h12};
        vecs[2] = '{0,   8'h33, 1'b0, 1'b0, 6,   0,    8'h00};
        vecs[3] = '{3,   8'hFE, 1'b0, 1'b1, 16,  12,   8'h00};
        vecs[4] = '{1,   8'h80, 1'b1, 1'b0, 14,  4,    8'h80};
        vecs[5] = '{255, 8'h05, 1'b0, 1'b0, 268, 1020, 8'h03};
        vecs[6] = '{4,   8'hFF, 1'b1, 1'b1, 17,  16,   8'h02};

        repeat (3) step();
        cmp("reset", sample(), '0);
        RST = 1'b0;
        step();
        cmp("idle", sample(), '0);

        for (int v = 0; v < 7; v++) begin
            if (!vecs[v].b2b) repeat (2) step();
            run_job($sformatf("job%0d", v), vecs[v].n, vecs[v].base, vecs[v].inject, dk, st, c0, dn);
            chk($sformatf("job%0d done_lat", v), 32'(dk), 32'(vecs[v].done_lat));
            chk($sformatf("job%0d done_cnt", v), 32'(dn), 32'd1);
            chk($sformatf("job%0d strobes", v), 32'(st), 32'(vecs[v].strobes));
            chk($sformatf("job%0d col0_last", v), 32'(c0), 32'(vecs[v].col0_last));
            if (v == 0) begin
                for (int k = 1; k <= 4; k++) begin
                    chk($sformatf("load w_en k=%0d", k), 32'(obs[k].wren), 32'd1);
                    chk($sformatf("load w_addr k=%0d", k), 32'(obs[k].waddr), 32'(k - 1));
                end
                for (int k = 2; k <= 5; k++) begin
                    chk($sformatf("load en_w k=%0d", k), 32'(obs[k].enw), 32'hF);
                    chk($sformatf("load en_id k=%0d", k), 32'(obs[k].enid), 32'(k - 2));
                end
            end
            if (v == 1) begin
                for (int t = 2; t <= 4; t++) begin
                    chk($sformatf("skew row2 en t=%0d", t), 32'(obs[6+t].ien[2]), 32'd1);
                    chk($sformatf("skew row2 idx t=%0d", t), 32'(obs[6+t].iaddr[23:16]), 32'(t - 2));
                end
                chk("skew row2 idle t=1", 32'(obs[7].ien[2]), 32'd0);
                chk("skew row2 idle t=5", 32'(obs[11].ien[2]), 32'd0);
                for (int t = 3; t <= 5; t++) begin
                    chk($sformatf("skew col3 valid t=%0d", t), 32'(obs[6+t].validp[3]), 32'd1);
                    chk($sformatf("skew col3 addr t=%0d", t), 32'(obs[6+t].addrp[31:24]), 32'h10 + 32'(t - 3));
                end
            end
            if (v == 3) begin
                chk("wrap col0 t=0", 32'(obs[6].addrp[7:0]), 32'hFE);
                chk("wrap col0 t=1", 32'(obs[7].addrp[7:0]), 32'hFF);
                chk("wrap col0 t=2", 32'(obs[8].addrp[7:0]), 32'h00);
            end
        end

        // reset held for three cycles in the middle of STREAM
        repeat (2) step();
        i_Start = 1'b1;
        i_Num_Vec = 8'd5;
        i_Base_Addr = 8'h40;
        step();
        i_Start = 1'b0;
        repeat (8) step();
        RST = 1'b1;
        for (int r = 0; r < 3; r++) begin
            step();
            cmp($sformatf("mid_rst r=%0d", r), sample(), '0);
        end
        RST = 1'b0;
        step();
        cmp("post_rst idle", sample(), '0);
        run_job("post_rst", 5, 8'h40, 1'b0, dk, st, c0, dn);
        chk("post_rst done_cnt", 32'(dn), 32'd1);

        for (int r = 0; r < 20; r++) begin
            int  n = $urandom_range(0, 12);
            int  b = $urandom_range(0, 255);
            bit  inj = 1'($urandom);
            if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) step();
            run_job($sformatf("rnd%0d", r), n, b, inj, dk, st, c0, dn);
            chk($sformatf("rnd%0d done_cnt", r), 32'(dn), 32'd1);
            chk($sformatf("rnd%0d strobes", r), 32'(st), 32'(PE_ROW * n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
